// File: rtl/hero_sprite_pkg.sv
// Shared defaults and types for the hero sprite fetch path.
// Optional feature macro: HERO_MIRROR_EN (horizontal mirroring, see hero_anim_seq).
package hero_sprite_pkg;

  typedef logic [2:0] pal_idx_t;

  typedef enum logic {
    HOLD,
    RUN
  } anim_state_t;

  localparam int unsigned SPR_W      = 24;
  localparam int unsigned SPR_H      = 34;
  localparam int unsigned NUM_FRAMES = 4;
  localparam int unsigned FRAME_DIV  = 8;
  localparam pal_idx_t    KEY_IDX    = 3'd0;

  // Width of a counter/index that must hold values 0..n-1 (never below 1 bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Sprite ROM address width for all frames stored back-to-back.
  function automatic int unsigned addr_w(input int unsigned n_frames, input int unsigned w,
                                         input int unsigned h);
    return cnt_w(n_frames * w * h);
  endfunction

endpackage

// File: rtl/hero_anim_seq.sv
// Walk-animation frame sequencer: vsync falling-edge detect, HOLD/RUN FSM,
// vsync divider and frame counter. Frame only changes on a vsync tick.
// Optional feature macro: HERO_MIRROR_EN (latches facing_left on each tick).
module hero_anim_seq
  import hero_sprite_pkg::*;
#(
  parameter int unsigned NUM_FRAMES = hero_sprite_pkg::NUM_FRAMES,
  parameter int unsigned FRAME_DIV  = hero_sprite_pkg::FRAME_DIV,
  localparam int unsigned FRAME_W   = cnt_w(NUM_FRAMES),
  localparam int unsigned DIV_W     = cnt_w(FRAME_DIV)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               vs_i,
  input  logic               anim_en_i,
  input  logic               facing_left_i,
  output logic [FRAME_W-1:0] frame_o,
  output logic               mirror_o
);

  logic               vs_q;
  logic               tick;
  anim_state_t        state_q;
  logic [DIV_W-1:0]   div_q;
  logic [FRAME_W-1:0] frame_q;

  // vs is active-low: a falling edge marks the start of a new video frame
  assign tick = vs_q & ~vs_i;

  // Vsync delay register for edge detection
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      vs_q <= 1'b1;
    end else begin
      vs_q <= vs_i;
    end
  end

  // Animation FSM with registered frame/divider; everything advances on tick only
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= HOLD;
      div_q   <= '0;
      frame_q <= '0;
    end else if (tick) begin
      unique case (state_q)
        HOLD: begin
          div_q   <= '0;
          frame_q <= '0;
          if (anim_en_i) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (!anim_en_i) begin
            state_q <= HOLD;
            div_q   <= '0;
            frame_q <= '0;
          end else if (div_q == DIV_W'(FRAME_DIV - 1)) begin
            div_q   <= '0;
            frame_q <= (frame_q == FRAME_W'(NUM_FRAMES - 1)) ? '0 : frame_q + FRAME_W'(1);
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
      endcase
    end
  end

  assign frame_o = frame_q;

`ifdef HERO_MIRROR_EN
  logic mirror_q;

  // Facing direction is sampled on tick so a mirror change never splits a frame
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mirror_q <= 1'b0;
    end else if (tick) begin
      mirror_q <= facing_left_i;
    end
  end

  assign mirror_o = mirror_q;
`else
  logic unused_facing_left;
  assign unused_facing_left = facing_left_i;
  assign mirror_o           = 1'b0;
`endif

endmodule

// File: rtl/hero_sprite_fetch.sv
// Hero sprite fetch: hit test against the sprite box, sprite ROM addressing
// for the current animation frame, and a registered palette index / valid
// flag. Fixed 3-cycle latency from DrawX/DrawY to index_out/pixel_valid.
// Optional feature macro: HERO_MIRROR_EN (horizontal mirroring on facing_left).
module hero_sprite_fetch
  import hero_sprite_pkg::*;
#(
  parameter int unsigned SPR_W      = hero_sprite_pkg::SPR_W,
  parameter int unsigned SPR_H      = hero_sprite_pkg::SPR_H,
  parameter int unsigned NUM_FRAMES = hero_sprite_pkg::NUM_FRAMES,
  parameter int unsigned FRAME_DIV  = hero_sprite_pkg::FRAME_DIV,
  parameter pal_idx_t    KEY_IDX    = hero_sprite_pkg::KEY_IDX,
  localparam int unsigned ADDR_W    = addr_w(NUM_FRAMES, SPR_W, SPR_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vs,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [10:0]       hero_x,
  input  logic [10:0]       hero_y,
  input  logic              anim_en,
  input  logic              facing_left,
  output logic [ADDR_W-1:0] rom_addr,
  input  pal_idx_t          rom_data,
  output pal_idx_t          index_out,
  output logic              pixel_valid
);

  localparam int unsigned COL_W   = cnt_w(SPR_W);
  localparam int unsigned ROW_W   = cnt_w(SPR_H);
  localparam int unsigned FRAME_W = cnt_w(NUM_FRAMES);

  logic [FRAME_W-1:0] frame;
  logic               mirror;

  hero_anim_seq #(
    .NUM_FRAMES(NUM_FRAMES),
    .FRAME_DIV (FRAME_DIV)
  ) u_anim_seq (
    .clk_i        (clk),
    .reset_i      (reset),
    .vs_i         (vs),
    .anim_en_i    (anim_en),
    .facing_left_i(facing_left),
    .frame_o      (frame),
    .mirror_o     (mirror)
  );

  // ---------------- S0: sprite-local coordinates and hit test ----------------
  logic [11:0]      lx, ly;
  logic             s0_hit;
  logic             s0_hit_q;
  logic [COL_W-1:0] s0_col_q;
  logic [ROW_W-1:0] s0_row_q;

  // 12-bit two's complement difference cannot overflow for 10-bit minus signed 11-bit
  always_comb begin
    lx     = {2'b00, DrawX} - {hero_x[10], hero_x};
    ly     = {2'b00, DrawY} - {hero_y[10], hero_y};
    s0_hit = ~lx[11] && (lx[10:0] < 11'(SPR_W)) && ~ly[11] && (ly[10:0] < 11'(SPR_H));
  end

  // S0 pipeline register; only the in-box low bits of lx/ly are kept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_hit_q <= 1'b0;
      s0_col_q <= '0;
      s0_row_q <= '0;
    end else begin
      s0_hit_q <= s0_hit;
      s0_col_q <= lx[COL_W-1:0];
      s0_row_q <= ly[ROW_W-1:0];
    end
  end

  // ---------------- S1: ROM address ----------------
  logic [COL_W-1:0]  s1_col;
  logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;
  logic              s1_hit_q;

  // Address only moves on a hit so the ROM bus stays quiet outside the sprite
  always_comb begin
    s1_col = mirror ? (COL_W'(SPR_W - 1) - s0_col_q) : s0_col_q;
    rom_addr_d = rom_addr_q;
    if (s0_hit_q) begin
      rom_addr_d = ADDR_W'(frame) * ADDR_W'(SPR_W * SPR_H)
                 + ADDR_W'(s0_row_q) * ADDR_W'(SPR_W)
                 + ADDR_W'(s1_col);
    end
  end

  // S1 pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_addr_q <= '0;
      s1_hit_q   <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      s1_hit_q   <= s0_hit_q;
    end
  end

  assign rom_addr = rom_addr_q;

  // ---------------- S2: palette index and opacity ----------------
  pal_idx_t index_q;
  logic     valid_q;

  // S2 output register; misses and key-coloured texels are transparent
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index_q <= '0;
      valid_q <= 1'b0;
    end else begin
      index_q <= s1_hit_q ? rom_data : KEY_IDX;
      valid_q <= s1_hit_q && (rom_data != KEY_IDX);
    end
  end

  assign index_out   = index_q;
  assign pixel_valid = valid_q;

endmodule

// File: tb/tb_hero_sprite_fetch.sv
// Scoreboard bench for hero_sprite_fetch. Stimulus pushes expectations, a
// negedge monitor pops them when the tracked pipeline slot reaches the output.
module tb_hero_sprite_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vs = 1'b1;
  logic [9:0]  DrawX, DrawY;
  logic [10:0] hero_x, hero_y;
  logic        anim_en, facing_left;
  logic [11:0] rom_addr;
  logic [2:0]  rom_data;
  logic [2:0]  index_out;
  logic        pixel_valid;

  hero_sprite_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .vs         (vs),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .hero_x     (hero_x),
    .hero_y     (hero_y),
    .anim_en    (anim_en),
    .facing_left(facing_left),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .index_out  (index_out),
    .pixel_valid(pixel_valid)
  );

  always #5 clk = ~clk;

  function automatic int rom_f(input int a);
    return (a & 7) ^ ((a >> 3) & 7) ^ ((a >> 6) & 7) ^ ((a >> 9) & 7);
  endfunction

  // Combinational ROM model: data valid in the cycle after rom_addr registers
  assign rom_data = 3'(rom_f(int'(rom_addr)));

  typedef struct {string name; int idx; int vld;} exp_out_t;
  typedef struct {string name; int addr;} exp_addr_t;

  exp_out_t  out_q[$];
  exp_addr_t addr_q[$];
  int        n_chk = 0;
  int        n_err = 0;

  logic       iss = 1'b0;
  logic [2:0] iss_pipe;

  // Reference model state
  int hx, hy;
  int m_frame = 0, m_div = 0, last_addr = 0;
  bit m_run = 0, m_mirror = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) iss_pipe <= '0;
    else       iss_pipe <= {iss_pipe[1:0], iss};
  end

  always @(negedge clk) begin : monitor
    exp_addr_t ea;
    exp_out_t  eo;
    if (!reset) begin
      if (iss_pipe[1]) begin
        if (addr_q.size() == 0) chk("addr_queue_underflow", 1, 0);
        else begin
          ea = addr_q.pop_front();
          chk({ea.name, "_addr"}, int'(rom_addr), ea.addr);
        end
      end
      if (iss_pipe[2]) begin
        if (out_q.size() == 0) chk("out_queue_underflow", 1, 0);
        else begin
          eo = out_q.pop_front();
          chk({eo.name, "_idx"}, int'(index_out), eo.idx);
          chk({eo.name, "_vld"}, int'(pixel_valid), eo.vld);
        end
      end
    end
  end

  task automatic set_hero(input int x, input int y);
    hx = x;
    hy = y;
    hero_x = 11'(x);
    hero_y = 11'(y);
  endtask

  task automatic pix(input string name, input int x, input int y);
    int lx, ly, col;
    bit hit;
    exp_out_t eo;
    exp_addr_t ea;
    @(negedge clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    lx = x - hx;
    ly = y - hy;
    hit = (lx >= 0) && (lx < 24) && (ly >= 0) && (ly < 34);
    if (hit) begin
      col = m_mirror ? 23 - lx : lx;
      last_addr = m_frame * 816 + ly * 24 + col;
    end
    ea.name = name;
    ea.addr = last_addr;
    addr_q.push_back(ea);
    eo.name = name;
    eo.idx  = hit ? rom_f(last_addr) : 0;
    eo.vld  = (hit && eo.idx != 0) ? 1 : 0;
    out_q.push_back(eo);
    iss = 1'b1;
    @(posedge clk);
    #1 iss = 1'b0;
  endtask

  task automatic vsync();
    @(negedge clk);
    vs = 1'b0;
    @(negedge clk);
    if (!m_run) begin
      if (anim_en) m_run = 1;
    end else if (!anim_en) begin
      m_run = 0;
      m_frame = 0;
      m_div = 0;
    end else if (m_div == 7) begin
      m_div = 0;
      m_frame = (m_frame + 1) % 4;
    end else begin
      m_div++;
    end
`ifdef HERO_MIRROR_EN
    m_mirror = facing_left;
`endif
    @(negedge clk);
    vs = 1'b1;
    @(negedge clk);
  endtask

  // Sub-cycle low pulse on vs that no clock edge ever samples
  task automatic glitch();
    @(negedge clk);
    #1 vs = 1'b0;
    #2 vs = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    anim_en = 1'b0;
    facing_left = 1'b0;
    set_hero(100, 200);
    DrawX = 10'd100;
    DrawY = 10'd200;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", int'(rom_addr), 0);
    chk("rst_idx", int'(index_out), 0);
    chk("rst_vld", int'(pixel_valid), 0);
    @(negedge clk);
    reset = 1'b0;

    // Frame 0 hits and misses around the sprite box
    pix("first", 100, 200);
    pix("col1", 101, 200);
    pix("row1", 100, 201);
    pix("mid", 110, 215);
    pix("last_f0", 123, 233);
    pix("miss_right", 124, 233);
    pix("miss_below", 123, 234);
    pix("miss_left", 99, 200);
    pix("miss_above", 100, 199);

    // Animation: 33 ticks walk frames 0,1,2,3,0
    anim_en = 1'b1;
    for (int i = 0; i < 33; i++) begin
      vsync();
      pix($sformatf("anim_t%0d", i + 1), 100 + (i % 24), 200 + i);
      if (m_frame == 2 && m_div == 0) pix("last_f2", 123, 233);
    end
    for (int i = 33; i < 56; i++) begin
      vsync();
      pix($sformatf("anim_t%0d", i + 1), 105, 210);
    end
    // Divider is one tick from a frame step; a glitch must not supply it
    glitch();
    pix("after_glitch", 105, 210);
    vsync();
    pix("frame3", 123, 233);
    anim_en = 1'b0;
    vsync();
    pix("drop_anim", 123, 233);
    // anim_en pulse between ticks is not seen
    anim_en = 1'b1;
    repeat (2) @(negedge clk);
    anim_en = 1'b0;
    vsync();
    pix("hold_after_pulse", 110, 210);

    // Partially off-screen sprite
    set_hero(-5, 0);
    pix("neg_x0", 0, 0);
    pix("neg_x18", 18, 0);
    pix("neg_x19", 19, 0);
    pix("neg_x17_y33", 17, 33);
    set_hero(-5, -3);
    pix("neg_y0", 0, 0);
    pix("neg_y31", 0, 31);
    set_hero(630, 470);
    pix("far_br", 639, 479);
    pix("far_beyond", 653, 479);
    set_hero(1000, 0);
    pix("far_miss", 5, 0);

    // Mirror request latched on tick
    set_hero(100, 200);
    facing_left = 1'b1;
    vsync();
    pix("mirror_c0", 100, 200);
    facing_left = 1'b0;
    pix("mirror_c5", 105, 203);

    // Asynchronous reset mid-line
    pix("pre_rst_a", 105, 205);
    pix("pre_rst_b", 106, 205);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_addr", int'(rom_addr), 0);
    chk("async_rst_idx", int'(index_out), 0);
    chk("async_rst_vld", int'(pixel_valid), 0);
    out_q.delete();
    addr_q.delete();
    m_frame = 0;
    m_div = 0;
    m_run = 0;
    m_mirror = 0;
    last_addr = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pix("post_rst", 110, 210);
    pix("post_rst_miss", 0, 0);

    repeat (5) @(negedge clk);
    chk("drain_out", out_q.size(), 0);
    chk("drain_addr", addr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
